inst_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache; the responder for the fetch unit's pc/inst request handshake.
//  - Serves hits from local storage.
//  - On a miss, refills a whole line from the memory controller with word reads, then replies.
//  - Sits between InstFetch and the memory controller's instruction port.

---
 rtl/inst_cache_pkg.sv | 13 +
 rtl/inst_cache_tag_array.sv | 40 ++++
 rtl/inst_cache.sv | 222 ++++++++++++++++++++++
 tb/tb_inst_cache.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: default geometry and FSM states.
package inst_cache_pkg;

  localparam int unsigned IC_DEFAULT_INDEX_BITS = 6;
  localparam int unsigned IC_DEFAULT_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_COOL   = 2'd2
  } icState_e;

endpackage

// File: rtl/inst_cache_tag_array.sv
// Valid bits and tags for the direct-mapped instruction cache.
// Hit lookup is combinational; one synchronous write port installs a line.
module ic_tag_array #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  input  logic [TAG_BITS-1:0]   rd_tag_i,
  output logic                  hit_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i
);

  localparam int unsigned NUM_LINES = 1 << INDEX_BITS;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q [NUM_LINES];

  // Valid bits: cleared by reset, set when a refilled line is installed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag storage needs no reset because the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between the fetch unit and the
// memory controller instruction port. Misses refill a whole line with word
// reads, then the request is looked up again and served as a hit.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = IC_DEFAULT_INDEX_BITS,
  parameter int unsigned LINE_WORDS = IC_DEFAULT_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        pc_valid,
  input  logic [31:0] pc_in,
  output logic        inst_ready,
  output logic [31:0] inst_out,
  output logic        mem_req_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_done,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OFF_BITS       = $clog2(LINE_WORDS);
  localparam int unsigned CTR_BITS       = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int unsigned TAG_BITS       = 32 - 2 - OFF_BITS - INDEX_BITS;
  localparam int unsigned DATA_ADDR_BITS = INDEX_BITS + OFF_BITS;
  localparam logic [31:0] LINE_MASK      = 32'(LINE_WORDS * 4 - 1);
  localparam logic [CTR_BITS-1:0] LAST_WORD = CTR_BITS'(LINE_WORDS - 1);

  icState_e            state_q, state_d;
  logic                instReady_q, instReady_d;
  logic [31:0]         instOut_q, instOut_d;
  logic                memReqEn_q, memReqEn_d;
  logic [31:0]         memAddr_q, memAddr_d;
  logic [31:0]         lineAddr_q, lineAddr_d;
  logic [CTR_BITS-1:0] ctr_q, ctr_d;
  logic                pendValid_q, pendValid_d;
  logic [31:0]         pendData_q, pendData_d;

  logic [INDEX_BITS-1:0]     pcIndex;
  logic [TAG_BITS-1:0]       pcTag;
  logic [DATA_ADDR_BITS-1:0] pcDataAddr;
  logic                      lineHit;

  logic                      tagWe;
  logic [INDEX_BITS-1:0]     wrIndex;
  logic [TAG_BITS-1:0]       wrTag;
  logic                      dataWe;
  logic [DATA_ADDR_BITS-1:0] dataWrAddr;
  logic [31:0]               dataWrData;

  logic                effDone;
  logic [31:0]         effData;
  logic [CTR_BITS-1:0] ctrNext;
  logic                countHit;
  logic                countMiss;

  logic [31:0] dataMem [2**DATA_ADDR_BITS];

  assign pcIndex    = INDEX_BITS'(pc_in >> (2 + OFF_BITS));
  assign pcTag      = TAG_BITS'(pc_in >> (2 + OFF_BITS + INDEX_BITS));
  assign pcDataAddr = DATA_ADDR_BITS'(pc_in >> 2);

  assign wrIndex    = INDEX_BITS'(lineAddr_q >> (2 + OFF_BITS));
  assign wrTag      = TAG_BITS'(lineAddr_q >> (2 + OFF_BITS + INDEX_BITS));
  assign dataWrAddr = DATA_ADDR_BITS'((lineAddr_q >> 2) | 32'(ctr_q));

  // A word that completed while frozen is replayed from the pending latch.
  assign effDone    = mem_done || pendValid_q;
  assign effData    = pendValid_q ? pendData_q : mem_data;
  assign dataWrData = effData;
  assign ctrNext    = ctr_q + CTR_BITS'(1);

  ic_tag_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (pcIndex),
    .rd_tag_i   (pcTag),
    .hit_o      (lineHit),
    .we_i       (tagWe),
    .wr_index_i (wrIndex),
    .wr_tag_i   (wrTag)
  );

  // Line data storage, written one word per completed memory read.
  always_ff @(posedge clk) begin
    if (dataWe) begin
      dataMem[dataWrAddr] <= dataWrData;
    end
  end

  // State and output registers; everything returns to idle on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IC_IDLE;
      instReady_q <= 1'b0;
      instOut_q   <= '0;
      memReqEn_q  <= 1'b0;
      memAddr_q   <= '0;
      lineAddr_q  <= '0;
      ctr_q       <= '0;
      pendValid_q <= 1'b0;
      pendData_q  <= '0;
    end else begin
      state_q     <= state_d;
      instReady_q <= instReady_d;
      instOut_q   <= instOut_d;
      memReqEn_q  <= memReqEn_d;
      memAddr_q   <= memAddr_d;
      lineAddr_q  <= lineAddr_d;
      ctr_q       <= ctr_d;
      pendValid_q <= pendValid_d;
      pendData_q  <= pendData_d;
    end
  end

  // Next-state logic: lookup in IDLE, word-by-word refill, one-cycle cool-down after a reply.
  always_comb begin
    state_d     = state_q;
    instReady_d = 1'b0;
    instOut_d   = instOut_q;
    memReqEn_d  = memReqEn_q;
    memAddr_d   = memAddr_q;
    lineAddr_d  = lineAddr_q;
    ctr_d       = ctr_q;
    pendValid_d = pendValid_q;
    pendData_d  = pendData_q;
    tagWe       = 1'b0;
    dataWe      = 1'b0;
    countHit    = 1'b0;
    countMiss   = 1'b0;

    if (!rdy) begin
      instReady_d = instReady_q;
      if ((state_q == IC_REFILL) && mem_done) begin
        pendValid_d = 1'b1;
        pendData_d  = mem_data;
      end
    end else begin
      pendValid_d = 1'b0;
      case (state_q)
        IC_IDLE: begin
          if (pc_valid) begin
            if (lineHit) begin
              instReady_d = 1'b1;
              instOut_d   = dataMem[pcDataAddr];
              countHit    = 1'b1;
              state_d     = IC_COOL;
            end else begin
              lineAddr_d = pc_in & ~LINE_MASK;
              memAddr_d  = pc_in & ~LINE_MASK;
              memReqEn_d = 1'b1;
              ctr_d      = '0;
              countMiss  = 1'b1;
              state_d    = IC_REFILL;
            end
          end
        end
        IC_REFILL: begin
          if (effDone) begin
            dataWe = 1'b1;
            if (ctr_q == LAST_WORD) begin
              tagWe      = 1'b1;
              memReqEn_d = 1'b0;
              ctr_d      = '0;
              state_d    = IC_IDLE;
            end else begin
              ctr_d     = ctrNext;
              memAddr_d = lineAddr_q | (32'(ctrNext) << 2);
            end
          end
        end
        IC_COOL: begin
          state_d = IC_IDLE;
        end
        default: begin
          state_d = IC_IDLE;
        end
      endcase
    end
  end

  assign inst_ready = instReady_q;
  assign inst_out   = instOut_q;
  assign mem_req_en = memReqEn_q;
  assign mem_addr   = memAddr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hitCnt_q;
  logic [31:0] missCnt_q;

  // Free-running hit and miss counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      if (countHit) begin
        hitCnt_q <= hitCnt_q + 32'd1;
      end
      if (countMiss) begin
        missCnt_q <= missCnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hitCnt_q;
  assign miss_cnt = missCnt_q;
`else
  logic unusedPerfEvents;
  assign unusedPerfEvents = countHit ^ countMiss;
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache with a fixed-latency memory model.
module tb_inst_cache;

`ifdef ICACHE_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic        mem_req_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_done;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int nChecks   = 0;
  int nFails    = 0;
  int doneCount = 0;
  int expHits   = 0;
  int expMisses = 0;
  logic [31:0] addrLog [$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] expInst;
    bit          expMiss;
  } vec_t;

  vec_t vecs [9];

  inst_cache dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .pc_valid   (pc_valid),
    .pc_in      (pc_in),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .mem_req_en (mem_req_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_done   (mem_done),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
    return 32'hA500_0000 | a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, "_hit_cnt"}, hit_cnt, PERF_EN ? 32'(expHits) : 32'd0);
    checkOutput({name, "_miss_cnt"}, miss_cnt, PERF_EN ? 32'(expMisses) : 32'd0);
  endtask

  // One fetch: hold pc_valid until the reply, then drop it during the cool-down cycle.
  task automatic applyStimulus(input logic [31:0] pc, output logic [31:0] inst, output bit missed,
                               output int latency, output int reqToReady, output bit gotIt);
    int cyc;
    int lastReq;
    cyc = 0;
    lastReq = -1;
    @(negedge clk);
    pc_valid = 1'b1;
    pc_in = pc;
    missed = 1'b0;
    gotIt = 1'b0;
    inst = '0;
    latency = 0;
    reqToReady = 0;
    while (!gotIt && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req_en) begin
        missed = 1'b1;
        lastReq = cyc;
      end
      if (inst_ready) begin
        gotIt = 1'b1;
        inst = inst_out;
        latency = cyc;
        reqToReady = cyc - lastReq;
      end
    end
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  task automatic waitDones(input int target, input string name);
    int cyc;
    cyc = 0;
    while (doneCount < target && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({name, "_wait_done"}, 32'(doneCount >= target), 32'd1);
  endtask

  // Memory controller: each word completes three cycles after it is requested.
  initial begin : memModel
    int waitCnt;
    waitCnt = 0;
    mem_done = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_done) begin
        mem_done = 1'b0;
      end else if (mem_req_en) begin
        waitCnt++;
        if (waitCnt == 3) begin
          mem_done = 1'b1;
          mem_data = memWord(mem_addr);
          addrLog.push_back(mem_addr);
          doneCount++;
          waitCnt = 0;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : mainTest
    logic [31:0] inst;
    bit missed;
    bit gotIt;
    bit sawReady;
    int latency;
    int reqToReady;
    int base;
    logic [31:0] logged;

    vecs[0] = '{pc: 32'h0000_0008, expInst: 32'h0000_0033, expMiss: 1'b0};
    vecs[1] = '{pc: 32'h0000_0010, expInst: 32'hA500_0010, expMiss: 1'b1};
    vecs[2] = '{pc: 32'h0000_001C, expInst: 32'hA500_001C, expMiss: 1'b0};
    vecs[3] = '{pc: 32'h0000_0400, expInst: 32'hA500_0400, expMiss: 1'b1};
    vecs[4] = '{pc: 32'h0000_040C, expInst: 32'hA500_040C, expMiss: 1'b0};
    vecs[5] = '{pc: 32'h0000_0000, expInst: 32'h0000_0011, expMiss: 1'b1};
    vecs[6] = '{pc: 32'h0000_000C, expInst: 32'h0000_0044, expMiss: 1'b0};
    vecs[7] = '{pc: 32'h0000_0410, expInst: 32'hA500_0410, expMiss: 1'b1};
    vecs[8] = '{pc: 32'h0000_0014, expInst: 32'hA500_0014, expMiss: 1'b1};

    rst = 1'b1;
    rdy = 1'b1;
    pc_valid = 1'b0;
    pc_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_inst_ready", 32'(inst_ready), 32'd0);
    checkOutput("reset_inst_out", inst_out, 32'd0);
    checkOutput("reset_mem_req_en", 32'(mem_req_en), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkCounters("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] cold miss");
    applyStimulus(32'h0000_0004, inst, missed, latency, reqToReady, gotIt);
    expMisses++;
    expHits++;
    checkOutput("cold_got_reply", 32'(gotIt), 32'd1);
    checkOutput("cold_missed", 32'(missed), 32'd1);
    checkOutput("cold_inst", inst, 32'h0000_0022);
    checkOutput("cold_reply_after_refill", 32'(reqToReady), 32'd2);
    checkOutput("cold_word_reads", 32'(addrLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logged = (i < addrLog.size()) ? addrLog[i] : 32'hDEAD_BEEF;
      checkOutput($sformatf("cold_mem_addr_%0d", i), logged, 32'(i * 4));
    end
    checkCounters("cold");

    $display("[TB] hit");
    applyStimulus(32'h0000_000C, inst, missed, latency, reqToReady, gotIt);
    expHits++;
    checkOutput("hit_got_reply", 32'(gotIt), 32'd1);
    checkOutput("hit_missed", 32'(missed), 32'd0);
    checkOutput("hit_inst", inst, 32'h0000_0044);
    checkOutput("hit_latency", 32'(latency), 32'd1);
    checkCounters("hit");

    $display("[TB] pc_valid held after reply");
    @(negedge clk);
    pc_valid = 1'b1;
    pc_in = 32'h0000_0004;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold_ready_%0d", k), 32'(inst_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    pc_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hold_ready_after_drop", 32'(inst_ready), 32'd0);
    checkOutput("hold_inst", inst_out, 32'h0000_0022);
    checkOutput("hold_no_mem_req", 32'(mem_req_en), 32'd0);
    expHits += 3;

    $display("[TB] vector table");
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].pc, inst, missed, latency, reqToReady, gotIt);
      expHits++;
      if (vecs[v].expMiss) expMisses++;
      checkOutput($sformatf("vec%0d_got_reply", v), 32'(gotIt), 32'd1);
      checkOutput($sformatf("vec%0d_inst", v), inst, vecs[v].expInst);
      checkOutput($sformatf("vec%0d_missed", v), 32'(missed), 32'(vecs[v].expMiss));
      checkOutput($sformatf("vec%0d_timing", v), vecs[v].expMiss ? 32'(reqToReady) : 32'(latency),
                  vecs[v].expMiss ? 32'd2 : 32'd1);
    end
    checkCounters("table");

    $display("[TB] request dropped mid-refill");
    applyStimulus(32'h0000_0404, inst, missed, latency, reqToReady, gotIt);
    expHits++;
    expMisses++;
    checkOutput("evict_inst", inst, 32'hA500_0404);
    base = doneCount;
    @(negedge clk);
    pc_valid = 1'b1;
    pc_in = 32'h0000_0004;
    waitDones(base + 2, "drop");
    @(negedge clk);
    pc_valid = 1'b0;
    expMisses++;
    sawReady = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (inst_ready) sawReady = 1'b1;
    end
    checkOutput("drop_no_reply", 32'(sawReady), 32'd0);
    checkOutput("drop_words_read", 32'(doneCount - base), 32'd4);
    checkOutput("drop_req_idle", 32'(mem_req_en), 32'd0);
    applyStimulus(32'h0000_0008, inst, missed, latency, reqToReady, gotIt);
    expHits++;
    checkOutput("drop_after_missed", 32'(missed), 32'd0);
    checkOutput("drop_after_inst", inst, 32'h0000_0033);
    checkOutput("drop_after_latency", 32'(latency), 32'd1);
    checkCounters("drop");

    $display("[TB] freeze with a word completing");
    base = doneCount;
    @(negedge clk);
    pc_valid = 1'b1;
    pc_in = 32'h0000_0030;
    waitDones(base + 1, "freeze");
    @(negedge clk);
    rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("freeze_addr_held", mem_addr, 32'h0000_0034);
    checkOutput("freeze_req_held", 32'(mem_req_en), 32'd1);
    checkOutput("freeze_word_completed", 32'(doneCount - base), 32'd2);
    @(negedge clk);
    rdy = 1'b1;
    gotIt = 1'b0;
    for (int k = 0; k < 100 && !gotIt; k++) begin
      @(posedge clk);
      #1;
      if (inst_ready) begin
        gotIt = 1'b1;
        inst = inst_out;
      end
    end
    @(negedge clk);
    pc_valid = 1'b0;
    expMisses++;
    expHits++;
    checkOutput("freeze_got_reply", 32'(gotIt), 32'd1);
    checkOutput("freeze_inst", inst, 32'hA500_0030);
    applyStimulus(32'h0000_0034, inst, missed, latency, reqToReady, gotIt);
    expHits++;
    checkOutput("freeze_captured_missed", 32'(missed), 32'd0);
    checkOutput("freeze_captured_word", inst, 32'hA500_0034);

    $display("[TB] reset during refill");
    base = doneCount;
    @(negedge clk);
    pc_valid = 1'b1;
    pc_in = 32'h0000_0020;
    waitDones(base + 2, "rstrefill");
    @(negedge clk);
    rst = 1'b1;
    pc_valid = 1'b0;
    @(posedge clk);
    #1;
    expHits = 0;
    expMisses = 0;
    checkOutput("rstrefill_req_dropped", 32'(mem_req_en), 32'd0);
    checkOutput("rstrefill_inst_ready", 32'(inst_ready), 32'd0);
    checkCounters("rstrefill");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h0000_0020, inst, missed, latency, reqToReady, gotIt);
    expMisses++;
    expHits++;
    checkOutput("rstrefill_refetch_reply", 32'(gotIt), 32'd1);
    checkOutput("rstrefill_refetch_missed", 32'(missed), 32'd1);
    checkOutput("rstrefill_refetch_inst", inst, 32'hA500_0020);
    checkCounters("rstrefill_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
